// File: rtl/if_id_buffer_pkg.sv
// Shared constants for the IF/ID stage: NOP encoding, buffer depth and entry width helper.
package if_id_buffer_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned IF_ID_DEPTH = 2;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  // Packed entry layout is {instr, pc, pc_plus4}.
  function automatic int unsigned entry_width(input int unsigned dw, input int unsigned aw);
    return dw + 2 * aw;
  endfunction

endpackage

// File: rtl/if_id_slot.sv
// One IF/ID buffer entry register with write enable.
module if_id_slot #(
  parameter int unsigned WIDTH = 96
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_buffer.sv
// Fetch-to-decode 2-entry instruction buffer with valid/ready handshake and flush.
// Optional IF_ID_PERF_EN adds stall/flush performance counters.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_W_DEF,
  parameter int unsigned ADDRESS_WIDTH = ADDR_W_DEF,
  parameter int unsigned DEPTH         = IF_ID_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_f,
  output logic                     ready_f,
  input  logic [DATA_WIDTH-1:0]    instr_f,
  input  logic [ADDRESS_WIDTH-1:0] pc_f,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
  input  logic                     flush_i,
  output logic                     valid_d,
  input  logic                     ready_d,
  output logic [DATA_WIDTH-1:0]    instr_d,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_flush_cnt
`endif
);

  localparam int unsigned EW = entry_width(DATA_WIDTH, ADDRESS_WIDTH);
  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned CW = 2;

  logic [CW-1:0]          count;
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic                   push;
  logic                   pop;
  logic [EW-1:0]          wr_entry;
  logic [EW-1:0]          rd_entry;
  logic [EW-1:0]          slot_q [IF_ID_DEPTH];
  logic [IF_ID_DEPTH-1:0] slot_we;

  assign ready_f  = (count != CW'(DEPTH));
  assign valid_d  = (count != '0);
  assign push     = valid_f & ready_f;
  assign pop      = valid_d & ready_d;
  assign wr_entry = {instr_f, pc_f, pc_plus4_f};

  for (genvar i = 0; i < IF_ID_DEPTH; i++) begin : g_slot
    assign slot_we[i] = push & ~flush_i & (wr_ptr == 1'(i));

    if_id_slot #(.WIDTH(EW)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (slot_we[i]),
      .d     (wr_entry),
      .q     (slot_q[i])
    );
  end

  // Flush wins over any same-cycle push/pop; empty state encoded as count==0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush_i) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      count  <= count + CW'(push) - CW'(pop);
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
    end
  end

  assign rd_entry = slot_q[rd_ptr];

  // Decode sees a NOP bubble with zero pcs whenever nothing is buffered.
  always_comb begin
    instr_d    = DATA_WIDTH'(NOP_INSTR);
    pc_d       = '0;
    pc_plus4_d = '0;
    if (valid_d) begin
      instr_d    = rd_entry[EW-1 -: DATA_WIDTH];
      pc_d       = rd_entry[2*AW-1 -: AW];
      pc_plus4_d = rd_entry[AW-1:0];
    end
  end

`ifdef IF_ID_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + 32'(valid_f & ~ready_f);
      perf_flush_cnt <= perf_flush_cnt + 32'(flush_i);
    end
  end
`endif

endmodule
